// File: rtl/scan_test_controller.sv
// Scan test controller: loads LFSR patterns into the scan chain, triggers capture,
// compresses the unloaded stream into a CRC, then checks CRC and stage signatures.
module scan_test_controller #(
  parameter int         CHAIN_LEN = 16,
  parameter int         NUM_PAT   = 8,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] gold_crc,
  input  logic [3:0]  gold_sig,
  input  logic        sc0,
  input  logic        sg0,
  output logic        sci,
  output logic        se0,
  output logic        se1,
  output logic        lck,
  output logic        trg,
  output logic        cs,
  output logic        sge,
  output logic        scj0,
  output logic        scj1,
  output logic        busy,
  output logic        done,
  output logic        pass
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(NUM_PAT + 1);

  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] LAST_PAT = PW'(NUM_PAT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_UNLOAD  = 3'd3;
  localparam logic [2:0] S_SIG     = 3'd4;
  localparam logic [2:0] S_COMPARE = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [BW-1:0] bitcnt, bitcnt_nxt;
  logic [PW-1:0] patcnt, patcnt_nxt;
  logic [1:0]    sigidx, sigidx_nxt;
  logic [7:0]    lfsr, lfsr_nxt;
  logic [15:0]   crc, crc_nxt;
  logic [3:0]    sigcap, sigcap_nxt;
  logic          pass_nxt;

  logic          lfsr_fb;
  logic [15:0]   crc_step;

  // x^8+x^6+x^5+x^4+1 in right-shift (Fibonacci) form
  assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4];
  assign crc_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ sc0) ? 16'h1021 : 16'h0000);

  always_comb begin
    // NOTE: every variable gets its hold value first so no branch can leave one
    // unassigned; that is what keeps this block from inferring latches.
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    patcnt_nxt = patcnt;
    sigidx_nxt = sigidx;
    lfsr_nxt   = lfsr;
    crc_nxt    = crc;
    sigcap_nxt = sigcap;
    pass_nxt   = pass;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_LOAD;
          bitcnt_nxt = '0;
          patcnt_nxt = '0;
          sigidx_nxt = '0;
          lfsr_nxt   = SEED;
          crc_nxt    = '0;
          sigcap_nxt = '0;
          pass_nxt   = 1'b0;
        end
      end

      S_LOAD: begin
        lfsr_nxt = {lfsr_fb, lfsr[7:1]};
        if (bitcnt == LAST_BIT) begin
          bitcnt_nxt = '0;
          state_nxt  = S_CAPTURE;
        end else begin
          bitcnt_nxt = bitcnt + 1'b1;
        end
      end

      S_CAPTURE: begin
        state_nxt = S_UNLOAD;
      end

      S_UNLOAD: begin
        crc_nxt = crc_step;
        if (bitcnt == LAST_BIT) begin
          bitcnt_nxt = '0;
          patcnt_nxt = patcnt + 1'b1;
          state_nxt  = (patcnt == LAST_PAT) ? S_SIG : S_LOAD;
        end else begin
          bitcnt_nxt = bitcnt + 1'b1;
        end
      end

      S_SIG: begin
        sigcap_nxt[sigidx] = sg0;
        sigidx_nxt         = sigidx + 1'b1;
        // The verdict is registered on the edge entering COMPARE so that pass is
        // already valid while done is high.
        if (sigidx == 2'd3) begin
          state_nxt = S_COMPARE;
          pass_nxt  = (crc == gold_crc) && (sigcap_nxt == gold_sig);
        end
      end

      S_COMPARE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with the
  // cycle the controller is actually in.
  logic       se0_nxt, se1_nxt, lck_nxt, trg_nxt, sge_nxt, busy_nxt, done_nxt;
  logic [1:0] scj_nxt;

  always_comb begin
    se1_nxt  = (state_nxt == S_LOAD) || (state_nxt == S_UNLOAD);
    se0_nxt  = (state_nxt == S_CAPTURE);
    lck_nxt  = (state_nxt == S_LOAD) || (state_nxt == S_CAPTURE) || (state_nxt == S_UNLOAD);
    trg_nxt  = (state_nxt == S_CAPTURE);
    sge_nxt  = (state_nxt == S_SIG);
    scj_nxt  = (state_nxt == S_SIG) ? sigidx_nxt : 2'd0;
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_COMPARE);
  end

  always_ff @(posedge Clk) begin
    // NOTE: state is written with <= so every flop samples pre-edge values.
    if (reset) begin
      state  <= S_IDLE;
      bitcnt <= '0;
      patcnt <= '0;
      sigidx <= '0;
      lfsr   <= SEED;
      crc    <= '0;
      sigcap <= '0;
      pass   <= 1'b0;
      se0    <= 1'b0;
      se1    <= 1'b0;
      lck    <= 1'b0;
      trg    <= 1'b0;
      cs     <= 1'b0;
      sge    <= 1'b0;
      scj0   <= 1'b0;
      scj1   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      bitcnt <= bitcnt_nxt;
      patcnt <= patcnt_nxt;
      sigidx <= sigidx_nxt;
      lfsr   <= lfsr_nxt;
      crc    <= crc_nxt;
      sigcap <= sigcap_nxt;
      pass   <= pass_nxt;
      se0    <= se0_nxt;
      se1    <= se1_nxt;
      lck    <= lck_nxt;
      trg    <= trg_nxt;
      cs     <= busy_nxt;
      sge    <= sge_nxt;
      scj0   <= scj_nxt[0];
      scj1   <= scj_nxt[1];
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  // Scan-in is the only combinational output: the current LFSR bit while loading.
  assign sci = lfsr[0] & (state == S_LOAD);

endmodule

// File: doc/scan_test_controller.md
Name: scan_test_controller

Overview:
- Scan test controller: the driving end of the scan-cluster and signature-register test top.
- Generates pseudo-random scan patterns and drives the chain's scan-in and mode controls.
- Issues capture triggers and unloads the chain serially, compressing the scan-out stream.
- Finally reads the four per-stage signature bits and reports pass/fail against golden values supplied by the host.

Parameters:
- CHAIN_LEN, 16, scan-chain length in bits (shift cycles per load/unload); minimum 1.
- NUM_PAT, 8, number of patterns per run; minimum 1.
- SEED, 8'hA5, reset/start value of the pattern LFSR; must be non-zero.

Ports:
- Clk, input, 1, single system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high; clears all state.
- start, input, 1, begin a run; sampled only in IDLE.
- gold_crc, input, 16, expected serial scan-out signature.
- gold_sig, input, 4, expected stage-signature bits, indexed by stage 0..3.
- sc0, input, 1, scan-chain serial output.
- sg0, input, 1, stage-signature output of the selected stage.
- sci, output, 1, scan-chain serial input.
- se0, output, 1, scan mode bit 0.
- se1, output, 1, scan mode bit 1.
- lck, output, 1, cluster enable.
- trg, output, 1, capture trigger to the pulse generator.
- cs, output, 1, clock select; 1 = pulse-generator clock.
- sge, output, 1, signature enable.
- scj0, output, 1, stage select bit 0.
- scj1, output, 1, stage select bit 1.
- busy, output, 1, run in progress.
- done, output, 1, one-cycle end-of-run pulse.
- pass, output, 1, result of the last run; held until the next start.

Behaviour:
- Reset: all outputs 0. State IDLE, lfsr = SEED, crc = 16'h0000, sigcap = 0, pattern count = 0, bit count = 0.
- Mode encoding on {se1,se0}: 00 hold, 01 functional capture, 10 scan shift, 11 never driven.
- cs = 1 whenever busy=1, otherwise 0.
- State machine: IDLE -> LOAD -> CAPTURE -> UNLOAD -> (LOAD if patterns remain, else SIG) -> COMPARE -> IDLE.
- IDLE:
  - On start=1: go to LOAD next cycle.
  - Set busy=1, reload lfsr = SEED, clear crc/sigcap/counters.
  - start while busy is ignored.
- LOAD (CHAIN_LEN cycles):
  - {se1,se0}=10, lck=1, sci = lfsr[0].
  - Each cycle: lfsr <= {fb, lfsr[7:1]} with fb = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[4] (x^8+x^6+x^5+x^4+1).
- CAPTURE (1 cycle):
  - {se1,se0}=01, lck=1, trg=1, sci=0.
  - lfsr does not advance.
- UNLOAD (CHAIN_LEN cycles):
  - {se1,se0}=10, lck=1, sci=0.
  - Each cycle: crc <= {crc[14:0],1'b0} ^ ((crc[15]^sc0) ? 16'h1021 : 16'h0000).
  - On the last cycle, increment the pattern count.
  - If count == NUM_PAT go to SIG, else go to LOAD.
- SIG (4 cycles, k = 0..3):
  - {scj1,scj0}=k, sge=1, {se1,se0}=00, lck=0.
  - sg0 is sampled at the end of cycle k into sigcap[k].
- COMPARE (1 cycle):
  - pass <= (crc == gold_crc) && (sigcap == gold_sig).
  - done=1 this cycle only; busy=0 from the next cycle.
- Cycle count: with start sampled at edge 0, done is high in cycle NUM_PAT*(2*CHAIN_LEN+1)+5.
- Counters:
  - Bit counter width is clog2(CHAIN_LEN+1) and wraps to 0 at each phase change.
  - Pattern counter width is clog2(NUM_PAT+1).
- Reset mid-run: on the next edge return to full reset state. pass=0, no done pulse.
- Outputs are registered except sci, which is lfsr[0] gated by the LOAD state.

Test Plan:
- Reset with all inputs toggling -> every output 0 for the cycle after reset; busy=0, pass=0.
- CHAIN_LEN=4, NUM_PAT=1, SEED=A5, sc0=0, sg0=0, gold_crc=0000, gold_sig=0, start pulse:
  - sci = 1,0,1,0 in LOAD cycles 1..4.
  - trg=1 only in cycle 5.
  - {se1,se0} = 10,10,10,10,01,10,10,10,10,00,00,00,00.
  - done in cycle 14 with pass=1.
- Same run with sc0=1 throughout UNLOAD and gold_crc=0000 -> crc≠0, pass=0, done still in cycle 14.
- sg0 driven high only when {scj1,scj0}=2, gold_sig=4'b0100 -> sigcap=0100, pass=1.
  - Same run with gold_sig=4'b0010 -> pass=0.
- NUM_PAT=3, CHAIN_LEN=4:
  - Exactly 3 trg pulses, 9 cycles apart.
  - lfsr advances 12 times, never during CAPTURE.
  - done in cycle 32.
  - A start pulse in cycle 7 has no effect.
- reset asserted in cycle 6 of a run -> next cycle busy=0, all outputs 0.
  - A subsequent start replays an identical sci sequence beginning 1,0,1,0.
